// File: rtl/ex_mdu.sv
// ex_mdu: E-stage multiply/divide unit owning HI/LO with fixed-latency busy modelling (divider enabled by `MDU_DIV_EN)
module ex_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StartE,
    input  logic [2:0]  MDOpE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic        MDUseD,
    output logic        BusyE,
    output logic [31:0] HIE,
    output logic [31:0] LOE,
    output logic        MDStallD
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
    logic        pwr_q, pwr_d;
    logic        sgn, is_mul, is_div;
    logic [63:0] prod;
    logic [31:0] div_hi, div_lo;
    assign sgn    = ~MDOpE[0];
    assign is_mul = MDOpE[2:1] == 2'b00;
    assign prod   = {{32{sgn & RD1E[31]}}, RD1E} * {{32{sgn & RD2E[31]}}, RD2E};
`ifdef MDU_DIV_EN
    logic        neg_a, neg_b;
    logic [31:0] a_abs, b_abs, q_u, r_u;
    assign is_div = MDOpE[2:1] == 2'b01;
    assign neg_a  = sgn & RD1E[31];
    assign neg_b  = sgn & RD2E[31];
    assign a_abs  = neg_a ? -RD1E : RD1E;
    assign b_abs  = neg_b ? -RD2E : RD2E;
    // a zero divisor never commits, so any non-zero stand-in keeps the divider well defined
    assign q_u    = a_abs / (b_abs == 32'd0 ? 32'd1 : b_abs);
    assign r_u    = a_abs % (b_abs == 32'd0 ? 32'd1 : b_abs);
    assign div_lo = (neg_a ^ neg_b) ? -q_u : q_u;
    assign div_hi = neg_a ? -r_u : r_u;
`else
    logic [31:0] unused_div_cycles;
    assign unused_div_cycles = DIV_CYCLES;
    assign is_div = 1'b0;
    assign div_lo = 32'd0;
    assign div_hi = 32'd0;
`endif
    assign BusyE    = state_q == BUSY;
    assign HIE      = hi_q;
    assign LOE      = lo_q;
    assign MDStallD = MDUseD & (BusyE | (StartE & (is_mul | is_div)));
    // next-state: launch a long op or move-to, count down while busy, commit on the final edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        if (state_q == IDLE) begin
            if (StartE & is_mul) begin
                phi_d   = prod[63:32];
                plo_d   = prod[31:0];
                pwr_d   = 1'b1;
                cnt_d   = 8'(MULT_CYCLES);
                state_d = BUSY;
            end else if (StartE & is_div) begin
                phi_d   = div_hi;
                plo_d   = div_lo;
                pwr_d   = |RD2E;
`ifdef MDU_DIV_EN
                cnt_d   = 8'(DIV_CYCLES);
`endif
                state_d = BUSY;
            end else if (StartE & (MDOpE == 3'b100)) begin
                hi_d = RD1E;
            end else if (StartE & (MDOpE == 3'b101)) begin
                lo_d = RD1E;
            end
        end else begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                state_d = IDLE;
                hi_d    = pwr_q ? phi_q : hi_q;
                lo_d    = pwr_q ? plo_q : lo_q;
            end
        end
    end
    // state and architectural registers, cleared asynchronously so in-flight work is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed self-checking bench for ex_mdu (div checks follow `MDU_DIV_EN)
module tb_ex_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StartE = 1'b0;
    logic [2:0]  MDOpE = 3'b000;
    logic [31:0] RD1E = 32'd0;
    logic [31:0] RD2E = 32'd0;
    logic        MDUseD = 1'b0;
    logic        BusyE, MDStallD;
    logic [31:0] HIE, LOE;
    int          n_cmp = 0;
    int          n_err = 0;

    ex_mdu dut (
        .clk(clk), .reset(reset), .StartE(StartE), .MDOpE(MDOpE), .RD1E(RD1E), .RD2E(RD2E),
        .MDUseD(MDUseD), .BusyE(BusyE), .HIE(HIE), .LOE(LOE), .MDStallD(MDStallD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        StartE = 1'b1;
        MDOpE  = op;
        RD1E   = a;
        RD2E   = b;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_hi", HIE, 32'd0);
        chk("rst_lo", LOE, 32'd0);
        chk("rst_busy", 32'(BusyE), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(BusyE), 32'd0);
        chk("idle_hi", HIE, 32'd0);
        // mult -2 * 3 with mfhi waiting in D, plus an ignored start mid-busy
        MDUseD = 1'b1;
        start(3'b000, 32'hFFFFFFFE, 32'd3);
        #1 chk("mult_stall_start", 32'(MDStallD), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mult_busy", 32'(BusyE), 32'd1);
            chk("mult_stall", 32'(MDStallD), 32'd1);
            chk("mult_hi_hold", HIE, 32'd0);
            StartE = (i == 1);
            RD1E   = 32'd5;
            RD2E   = 32'd5;
        end
        @(negedge clk);
        chk("mult_busy_end", 32'(BusyE), 32'd0);
        chk("mult_stall_end", 32'(MDStallD), 32'd0);
        chk("mult_hi", HIE, 32'hFFFFFFFF);
        chk("mult_lo", LOE, 32'hFFFFFFFA);
        MDUseD = 1'b0;
        // multu, started in the first idle cycle
        start(3'b001, 32'hFFFFFFFE, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            StartE = 1'b0;
            chk("multu_busy", 32'(BusyE), 32'd1);
        end
        @(negedge clk);
        chk("multu_busy_end", 32'(BusyE), 32'd0);
        chk("multu_hi", HIE, 32'h00000002);
        chk("multu_lo", LOE, 32'hFFFFFFFA);
        // mthi then mtlo on consecutive cycles
        start(3'b100, 32'h12345678, 32'd0);
        @(negedge clk);
        chk("mthi_hi", HIE, 32'h12345678);
        chk("mthi_lo", LOE, 32'hFFFFFFFA);
        chk("mthi_busy", 32'(BusyE), 32'd0);
        start(3'b101, 32'h9ABCDEF0, 32'd0);
        @(negedge clk);
        chk("mtlo_lo", LOE, 32'h9ABCDEF0);
        chk("mtlo_hi", HIE, 32'h12345678);
        chk("mtlo_busy", 32'(BusyE), 32'd0);
        StartE = 1'b0;
`ifdef MDU_DIV_EN
        start(3'b010, 32'hFFFFFFF9, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            StartE = 1'b0;
            chk("div_busy", 32'(BusyE), 32'd1);
        end
        @(negedge clk);
        chk("div_lo", LOE, 32'hFFFFFFFD);
        chk("div_hi", HIE, 32'hFFFFFFFF);
        start(3'b011, 32'd7, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            StartE = 1'b0;
            chk("divu0_busy", 32'(BusyE), 32'd1);
        end
        @(negedge clk);
        chk("divu0_lo", LOE, 32'hFFFFFFFD);
        chk("divu0_hi", HIE, 32'hFFFFFFFF);
        start(3'b010, 32'h80000000, 32'hFFFFFFFF);
        repeat (11) begin
            @(negedge clk);
            StartE = 1'b0;
        end
        chk("divovf_lo", LOE, 32'h80000000);
        chk("divovf_hi", HIE, 32'd0);
`else
        MDUseD = 1'b1;
        start(3'b010, 32'd10, 32'd3);
        #1 chk("nodiv_stall", 32'(MDStallD), 32'd0);
        @(negedge clk);
        chk("nodiv_busy", 32'(BusyE), 32'd0);
        chk("nodiv_hi", HIE, 32'h12345678);
        chk("nodiv_lo", LOE, 32'h9ABCDEF0);
        start(3'b011, 32'd10, 32'd3);
        @(negedge clk);
        StartE = 1'b0;
        MDUseD = 1'b0;
        chk("nodivu_busy", 32'(BusyE), 32'd0);
        chk("nodivu_lo", LOE, 32'h9ABCDEF0);
`endif
        // async reset at the third busy cycle of a mult
        start(3'b000, 32'hFFFFFFFE, 32'd3);
        repeat (3) begin
            @(negedge clk);
            StartE = 1'b0;
        end
        chk("pre_rst_busy", 32'(BusyE), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(BusyE), 32'd0);
        chk("arst_hi", HIE, 32'd0);
        chk("arst_lo", LOE, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", 32'(BusyE), 32'd0);
        chk("post_rst_hi", HIE, 32'd0);
        chk("post_rst_lo", LOE, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
